// File: rtl/vpg_mode_ctrl_if.sv
// vpg_mode_ctrl_if: user-input and pattern-generator control signals of the
// video pattern generator front end. The master side is the controller, which
// reads the raw buttons/switches and drives mode/mode_change/disp_color. The
// slave side is whoever drives the buttons and consumes the control outputs.
interface vpg_mode_ctrl_if;
  logic       key_mode_n;
  logic       key_color_n;
  logic       sw_direct_en;
  logic [2:0] sw_mode;
  logic [3:0] mode;
  logic       mode_change;
  logic [1:0] disp_color;
  logic [2:0] mode_index;
  logic       busy;

  modport master (
    input  key_mode_n,
    input  key_color_n,
    input  sw_direct_en,
    input  sw_mode,
    output mode,
    output mode_change,
    output disp_color,
    output mode_index,
    output busy
  );

  modport slave (
    output key_mode_n,
    output key_color_n,
    output sw_direct_en,
    output sw_mode,
    input  mode,
    input  mode_change,
    input  disp_color,
    input  mode_index,
    input  busy
  );
endinterface

// File: rtl/vpg_mode_ctrl.sv
// vpg_mode_ctrl: pushbutton/switch front end for the video pattern generator.
// Synchronises and debounces the mode/colour keys and the mode switch bank,
// steps through the video-mode table, and issues a fixed-width mode_change
// pulse followed by a hold-off window so the downstream PLL reconfiguration
// can finish before another change is accepted.
// Optional build macro VPG_MODE_CTRL_STARTUP_PULSE_EN: when defined, the first
// clock after reset issues a mode_change pulse for index 0 so the PLL is set
// to the 640x480 clock at power-up.

// VpgModeCtrlDebounce: 2-flop synchroniser followed by a stability filter.
// The accepted level takes the synchronised value once it has been seen
// unchanged for CYCLES consecutive clocks. level_next_o is the value the
// accepted level takes at the coming edge, so edge events can be acted on in
// the same cycle the level is accepted.
module VpgModeCtrlDebounce #(
  parameter int               WIDTH       = 1,
  parameter int               CYCLES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_100,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] level_next_o
);
  localparam int               CNT_W    = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CYCLES);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stability counter: any change reloads it, otherwise it counts up to its terminal value.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q != cand_q) begin
      cnt_d = '0;
    end else begin
      if (cnt_q >= CNT_LAST) begin
        level_d = cand_q;
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, candidate, counter and accepted-level registers.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= RESET_VALUE;
      sync_q  <= RESET_VALUE;
      cand_q  <= RESET_VALUE;
      level_q <= RESET_VALUE;
      cnt_q   <= '0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      cand_q  <= sync_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o      = level_q;
  assign level_next_o = level_d;
endmodule

module vpg_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4,
  parameter int HOLDOFF_CYCLES  = 5000000
) (
  input  logic            clk_100,
  input  logic            reset_n,
  vpg_mode_ctrl_if.master ctrl_if
);
  // Mode codes understood by the pattern generator (vpg.h).
  localparam logic [3:0] VGA_640x480p60    = 4'd0;
  localparam logic [3:0] MODE_720x480      = 4'd1;
  localparam logic [3:0] MODE_1024x768     = 4'd2;
  localparam logic [3:0] MODE_1280x1024    = 4'd3;
  localparam logic [3:0] FHD_1920x1080p60  = 4'd4;
  localparam logic [3:0] VESA_1600x1200p60 = 4'd5;

  localparam logic [2:0] LAST_INDEX = 3'd5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam int               FSM_MAX    = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int               FSM_W      = $clog2(FSM_MAX + 1);
  localparam logic [FSM_W-1:0] PULSE_LAST = FSM_W'(PULSE_CYCLES - 1);
  localparam logic [FSM_W-1:0] HOLD_LAST  = FSM_W'(HOLDOFF_CYCLES - 1);

`ifdef VPG_MODE_CTRL_STARTUP_PULSE_EN
  localparam logic STARTUP_PULSE = 1'b1;
`else
  localparam logic STARTUP_PULSE = 1'b0;
`endif

  function automatic logic [3:0] modeCode(input logic [2:0] idx);
    case (idx)
      3'd0:    modeCode = VGA_640x480p60;
      3'd1:    modeCode = MODE_720x480;
      3'd2:    modeCode = MODE_1024x768;
      3'd3:    modeCode = MODE_1280x1024;
      3'd4:    modeCode = FHD_1920x1080p60;
      3'd5:    modeCode = VESA_1600x1200p60;
      default: modeCode = VGA_640x480p60;
    endcase
  endfunction

  logic       keyModeLevel;
  logic       keyModeLevelNext;
  logic       keyColorLevel;
  logic       keyColorLevelNext;
  logic [2:0] swLevel;
  logic [2:0] swLevelNext;

  logic dirMeta_q;
  logic dirSync_q;
  logic dirPrev_q;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [FSM_W-1:0] fsmCnt_q;
  logic [FSM_W-1:0] fsmCnt_d;
  logic [2:0]       modeIndex_q;
  logic [2:0]       modeIndex_d;
  logic [3:0]       mode_q;
  logic             modeChange_q;
  logic [1:0]       color_q;
  logic [1:0]       color_d;
  logic             startup_q;

  logic keyModePress;
  logic keyColorPress;
  logic swChanged;
  logic dirRise;
  logic directReq;
  logic stepReq;

  VpgModeCtrlDebounce #(
    .WIDTH(1), .CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(1'b1)
  ) uKeyModeDb (
    .clk_100(clk_100), .reset_n(reset_n), .async_i(ctrl_if.key_mode_n),
    .level_o(keyModeLevel), .level_next_o(keyModeLevelNext)
  );

  VpgModeCtrlDebounce #(
    .WIDTH(1), .CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(1'b1)
  ) uKeyColorDb (
    .clk_100(clk_100), .reset_n(reset_n), .async_i(ctrl_if.key_color_n),
    .level_o(keyColorLevel), .level_next_o(keyColorLevelNext)
  );

  VpgModeCtrlDebounce #(
    .WIDTH(3), .CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(3'd0)
  ) uSwModeDb (
    .clk_100(clk_100), .reset_n(reset_n), .async_i(ctrl_if.sw_mode),
    .level_o(swLevel), .level_next_o(swLevelNext)
  );

  // Direct-mode enable is a static switch: synchronise it and keep one more stage to spot its rising edge.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      dirMeta_q <= 1'b0;
      dirSync_q <= 1'b0;
      dirPrev_q <= 1'b0;
    end else begin
      dirMeta_q <= ctrl_if.sw_direct_en;
      dirSync_q <= dirMeta_q;
      dirPrev_q <= dirSync_q;
    end
  end

  // Request decoding: key presses are accepted-level falls, switch requests are accepted-value changes.
  always_comb begin
    keyModePress  = keyModeLevel & ~keyModeLevelNext;
    keyColorPress = keyColorLevel & ~keyColorLevelNext;
    swChanged     = (swLevelNext != swLevel);
    dirRise       = dirSync_q & ~dirPrev_q;
    directReq     = dirSync_q & (swChanged | dirRise) &
                    (swLevelNext <= LAST_INDEX) & (swLevelNext != modeIndex_q);
    stepReq       = keyModePress & ~dirSync_q;
  end

  // Mode FSM: IDLE accepts one request, PULSE holds mode_change, HOLDOFF drops everything until the PLL settles.
  always_comb begin
    state_d     = state_q;
    fsmCnt_d    = fsmCnt_q;
    modeIndex_d = modeIndex_q;
    case (state_q)
      ST_IDLE: begin
        fsmCnt_d = '0;
        if (startup_q) begin
          modeIndex_d = 3'd0;
          state_d     = ST_PULSE;
        end else if (directReq) begin
          modeIndex_d = swLevelNext;
          state_d     = ST_PULSE;
        end else if (stepReq) begin
          modeIndex_d = (modeIndex_q == LAST_INDEX) ? 3'd0 : modeIndex_q + 3'd1;
          state_d     = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (fsmCnt_q == PULSE_LAST) begin
          fsmCnt_d = '0;
          state_d  = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
        end else begin
          fsmCnt_d = fsmCnt_q + FSM_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (fsmCnt_q == HOLD_LAST) begin
          fsmCnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          fsmCnt_d = fsmCnt_q + FSM_W'(1);
        end
      end
      default: begin
        fsmCnt_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Colour select steps on every colour press regardless of the mode FSM.
  always_comb begin
    color_d = color_q;
    if (keyColorPress) begin
      color_d = color_q + 2'd1;
    end
  end

  // State and output registers; mode and mode_change change on the same edge as the index.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fsmCnt_q     <= '0;
      modeIndex_q  <= 3'd0;
      mode_q       <= VGA_640x480p60;
      modeChange_q <= 1'b0;
      color_q      <= 2'd0;
      startup_q    <= STARTUP_PULSE;
    end else begin
      state_q      <= state_d;
      fsmCnt_q     <= fsmCnt_d;
      modeIndex_q  <= modeIndex_d;
      mode_q       <= modeCode(modeIndex_d);
      modeChange_q <= (state_d == ST_PULSE);
      color_q      <= color_d;
      startup_q    <= 1'b0;
    end
  end

  assign ctrl_if.mode        = mode_q;
  assign ctrl_if.mode_change = modeChange_q;
  assign ctrl_if.disp_color  = color_q;
  assign ctrl_if.mode_index  = modeIndex_q;
  assign ctrl_if.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// tb_vpg_mode_ctrl: self-checking bench for vpg_mode_ctrl with short debounce,
// pulse and hold-off settings. A behavioural model predicts every output each
// cycle; table-driven steps and hand sequences add end-of-step checks.
`timescale 1ns/1ps
module tb_vpg_mode_ctrl;
  localparam int DB   = 8;
  localparam int PW   = 4;
  localparam int HO   = 32;
  localparam int HIST = DB + 2;

  logic clk_100 = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk_100 = ~clk_100;

  vpg_mode_ctrl_if bus();

  vpg_mode_ctrl #(
    .DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PW), .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk_100(clk_100), .reset_n(reset_n), .ctrl_if(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: inputs are seen two clocks late, a level is accepted when
  // DB+1 consecutive seen samples agree, and a request is honoured only if the
  // controller was not busy during the previous cycle.
  int         cyc;
  logic [2:0] mIndex;
  logic [1:0] mColor;
  bit         mStarted;
  int         mStart;
  logic       accMode, accColor;
  logic [2:0] accSw;
  logic       hMode[0:HIST];
  logic       hColor[0:HIST];
  logic [2:0] hSw[0:HIST];
  logic       hDir[0:HIST];

  int   pulseCount, highCycles, busyCycles, firstHigh;
  logic lastChange;

  typedef struct {
    bit         pressMode;
    bit         pressColor;
    logic       dirEn;
    logic [2:0] sw;
    logic [2:0] expIndex;
    logic [3:0] expMode;
    int         expPulses;
    logic [1:0] expColor;
  } step_t;

  step_t steps[19];

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void modelReset();
    cyc      = 0;
    mIndex   = 3'd0;
    mColor   = 2'd0;
    mStarted = 1'b0;
    mStart   = 0;
    accMode  = 1'b1;
    accColor = 1'b1;
    accSw    = 3'd0;
    for (int i = 0; i <= HIST; i++) begin
      hMode[i]  = 1'b1;
      hColor[i] = 1'b1;
      hSw[i]    = 3'd0;
      hDir[i]   = 1'b0;
    end
  endfunction

  function automatic void clearStats();
    pulseCount = 0;
    highCycles = 0;
    busyCycles = 0;
    firstHigh  = -1;
    lastChange = bus.mode_change;
  endfunction

  function automatic void modelEdge();
    logic       newMode, newColor;
    logic [2:0] newSw;
    bit         allMode, allColor, allSw, idle, dirSeen, dirRise;
    cyc++;
    for (int i = HIST; i > 0; i--) begin
      hMode[i]  = hMode[i-1];
      hColor[i] = hColor[i-1];
      hSw[i]    = hSw[i-1];
      hDir[i]   = hDir[i-1];
    end
    hMode[0]  = bus.key_mode_n;
    hColor[0] = bus.key_color_n;
    hSw[0]    = bus.sw_mode;
    hDir[0]   = bus.sw_direct_en;
    allMode = 1'b1; allColor = 1'b1; allSw = 1'b1;
    for (int i = 3; i <= HIST; i++) begin
      if (hMode[i] != hMode[2])   allMode  = 1'b0;
      if (hColor[i] != hColor[2]) allColor = 1'b0;
      if (hSw[i] != hSw[2])       allSw    = 1'b0;
    end
    newMode  = allMode  ? hMode[2]  : accMode;
    newColor = allColor ? hColor[2] : accColor;
    newSw    = allSw    ? hSw[2]    : accSw;
    dirSeen  = hDir[2];
    dirRise  = hDir[2] && !hDir[3];
    idle     = !(mStarted && (cyc - 1 - mStart) < PW + HO);
    if (idle) begin
      if (dirSeen) begin
        if ((newSw != accSw || dirRise) && newSw <= 3'd5 && newSw != mIndex) begin
          mIndex = newSw; mStarted = 1'b1; mStart = cyc;
        end
      end else if (accMode && !newMode) begin
        mIndex = (mIndex == 3'd5) ? 3'd0 : mIndex + 3'd1;
        mStarted = 1'b1; mStart = cyc;
      end
    end
    if (accColor && !newColor) mColor = mColor + 2'd1;
    accMode  = newMode;
    accColor = newColor;
    accSw    = newSw;
  endfunction

  task automatic checkOutput();
    bit expPulse, expBusy;
    expPulse = mStarted && (cyc - mStart) < PW;
    expBusy  = mStarted && (cyc - mStart) < PW + HO;
    checkVal("mode_change", int'(bus.mode_change), int'(expPulse));
    checkVal("busy", int'(bus.busy), int'(expBusy));
    checkVal("mode_index", int'(bus.mode_index), int'(mIndex));
    checkVal("mode", int'(bus.mode), int'(mIndex));
    checkVal("disp_color", int'(bus.disp_color), int'(mColor));
    if (bus.mode_change) highCycles++;
    if (bus.busy) busyCycles++;
    if (bus.mode_change && !lastChange) begin
      pulseCount++;
      if (firstHigh < 0) firstHigh = cyc;
    end
    lastChange = bus.mode_change;
  endtask

  task automatic tick();
    @(posedge clk_100);
    modelEdge();
    @(negedge clk_100);
    checkOutput();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic keyMode, input logic keyColor, input logic dirEn, input logic [2:0] sw);
    bus.key_mode_n   = keyMode;
    bus.key_color_n  = keyColor;
    bus.sw_direct_en = dirEn;
    bus.sw_mode      = sw;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0);
    repeat (3) @(negedge clk_100);
    checkVal("reset_mode_change", int'(bus.mode_change), 0);
    checkVal("reset_busy", int'(bus.busy), 0);
    checkVal("reset_mode_index", int'(bus.mode_index), 0);
    checkVal("reset_mode", int'(bus.mode), 0);
    checkVal("reset_disp_color", int'(bus.disp_color), 0);
    modelReset();
    clearStats();
    reset_n = 1'b1;
  endtask

  initial begin
    int pressCyc, bounceP, waited;

    steps[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 4'd1, 1, 2'd0};
    steps[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 4'd2, 1, 2'd0};
    steps[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 4'd3, 1, 2'd0};
    steps[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 4'd4, 1, 2'd0};
    steps[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 4'd5, 1, 2'd0};
    steps[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 1, 2'd0};
    steps[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 4'd0, 0, 2'd1};
    steps[7]  = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd1, 4'd1, 1, 2'd2};
    steps[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 4'd1, 0, 2'd3};
    steps[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 4'd1, 0, 2'd0};
    steps[10] = '{1'b0, 1'b0, 1'b0, 3'd4, 3'd1, 4'd1, 0, 2'd0};
    steps[11] = '{1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 4'd4, 1, 2'd0};
    steps[12] = '{1'b0, 1'b0, 1'b1, 3'd7, 3'd4, 4'd4, 0, 2'd0};
    steps[13] = '{1'b1, 1'b0, 1'b1, 3'd7, 3'd4, 4'd4, 0, 2'd0};
    steps[14] = '{1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 4'd4, 0, 2'd0};
    steps[15] = '{1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 4'd2, 1, 2'd0};
    steps[16] = '{1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 4'd3, 1, 2'd0};
    steps[17] = '{1'b0, 1'b0, 1'b0, 3'd6, 3'd3, 4'd3, 0, 2'd0};
    steps[18] = '{1'b0, 1'b0, 1'b1, 3'd6, 3'd3, 4'd3, 0, 2'd0};

    modelReset();
    clearStats();

    $display("[TB] clean press latency and pulse width");
    applyReset();
    pressCyc = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    run(20);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0);
    run(50);
    checkVal("clean_pulse_count", pulseCount, 1);
    checkVal("clean_pulse_width", highCycles, PW);
    checkVal("clean_pulse_latency", firstHigh - pressCyc, 11);
    checkVal("clean_busy_cycles", busyCycles, PW + HO);
    checkVal("clean_mode", int'(bus.mode), 1);

    $display("[TB] bouncing key");
    applyReset();
    for (int s = 0; s < 10; s++) begin
      applyStimulus((s % 2 == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, 3'd0);
      run(3);
    end
    bounceP = pulseCount;
    checkVal("bounce_no_pulse", bounceP, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    run(20);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0);
    run(50);
    checkVal("bounce_pulse_count", pulseCount, 1);
    checkVal("bounce_index", int'(bus.mode_index), 1);

    $display("[TB] press during hold-off");
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0); run(9);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0); run(9);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0); run(20);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0); run(40);
    checkVal("holdoff_pulse_count", pulseCount, 1);
    checkVal("holdoff_index", int'(bus.mode_index), 1);

    $display("[TB] table-driven steps");
    applyReset();
    for (int i = 0; i < 19; i++) begin
      clearStats();
      applyStimulus(steps[i].pressMode ? 1'b0 : 1'b1, steps[i].pressColor ? 1'b0 : 1'b1,
                    steps[i].dirEn, steps[i].sw);
      run(15);
      applyStimulus(1'b1, 1'b1, steps[i].dirEn, steps[i].sw);
      run(45);
      checkVal($sformatf("step%0d_index", i), int'(bus.mode_index), int'(steps[i].expIndex));
      checkVal($sformatf("step%0d_mode", i), int'(bus.mode), int'(steps[i].expMode));
      checkVal($sformatf("step%0d_pulses", i), pulseCount, steps[i].expPulses);
      checkVal($sformatf("step%0d_color", i), int'(bus.disp_color), int'(steps[i].expColor));
    end

    $display("[TB] reset during pulse");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd6);
    waited = 0;
    while (!bus.mode_change && waited < 30) begin
      tick();
      waited++;
    end
    checkVal("pulse_seen_before_reset", int'(bus.mode_change), 1);
    tick();
    reset_n = 1'b0;
    #1;
    checkVal("async_reset_mode_change", int'(bus.mode_change), 0);
    checkVal("async_reset_index", int'(bus.mode_index), 0);
    checkVal("async_reset_busy", int'(bus.busy), 0);
    checkVal("async_reset_mode", int'(bus.mode), 0);
    applyReset();

    $display("[TB] randomized stimulus");
    for (int s = 0; s < 45; s++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      run(int'($urandom_range(2, 30)));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0);
    run(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
